// File: rtl/srv_icache_refill.sv
// srv_icache_refill: line-refill engine behind the instruction cache.
// On a miss it fetches the whole line as LINE_WORDS 32-bit beats. Beats are
// fetched in wrap-around order, starting with the requested word. The engine
// then returns the assembled line with a one-cycle response pulse.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   line_req_i          miss request (level, sampled only in IDLE)
//   line_addr_i         miss byte address
//   line_rsp_o          one-cycle pulse, line_data_o valid
//   line_data_o         refilled line, word k at bits [32k+31:32k]
//   busy_o              engine not idle
//   mem_req_o/_addr_o   beat request and word-aligned byte address
//   mem_gnt_i           beat request accepted
//   mem_rvalid_i/_rdata_i  in-order beat return
//
// state | meaning
// IDLE  | waiting for a miss
// FETCH | issuing beat requests, collecting returns
// DRAIN | all beats issued, waiting for the remaining returns
// RESP  | line_rsp_o pulse, line complete
module srv_icache_refill #(
  parameter int LINE_WORDS = 4,
  parameter int MAX_OUTST  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    line_req_i,
  input  logic [31:0]             line_addr_i,
  output logic                    line_rsp_o,
  output logic [32*LINE_WORDS-1:0] line_data_o,
  output logic                    busy_o,
  output logic                    mem_req_o,
  output logic [31:0]             mem_addr_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [31:0]             mem_rdata_i
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int CW = OW + 1;
  localparam int BW = 30 - OW;
  localparam logic [CW-1:0] LW_C  = CW'(LINE_WORDS);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_RESP} state_e;

  state_e                         state_q, state_d;
  logic [BW-1:0]                  base_q, base_d;
  logic [OW-1:0]                  start_q, start_d;
  logic [CW-1:0]                  ic_q, ic_d;
  logic [CW-1:0]                  rc_q, rc_d;
  logic [LINE_WORDS-1:0][31:0]    line_q, line_d;

  logic [CW-1:0] outst;
  logic          issue_ok;
  logic          gnt_fire;
  logic          rsp_fire;
  logic [OW-1:0] issue_idx;
  logic [OW-1:0] wr_idx;

  // Outstanding count uses registered values only, so the request cannot
  // combinationally depend on a same-cycle rvalid.
  assign outst     = ic_q - rc_q;
  assign issue_ok  = (state_q == S_FETCH) && (ic_q < LW_C) && (outst < MAX_C);
  assign gnt_fire  = issue_ok && mem_gnt_i;
  // A return with nothing outstanding is a protocol error and is dropped.
  assign rsp_fire  = ((state_q == S_FETCH) || (state_q == S_DRAIN)) &&
                     mem_rvalid_i && (outst != '0);
  // OW-bit addition wraps modulo LINE_WORDS.
  assign issue_idx = start_q + ic_q[OW-1:0];
  assign wr_idx    = start_q + rc_q[OW-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      start_q <= '0;
      ic_q    <= '0;
      rc_q    <= '0;
      line_q  <= '0;
    end else begin
      base_q  <= base_d;
      start_q <= start_d;
      ic_q    <= ic_d;
      rc_q    <= rc_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    base_d  = base_q;
    start_d = start_q;
    ic_d    = ic_q;
    rc_d    = rc_q;
    line_d  = line_q;
    if ((state_q == S_IDLE) && line_req_i) begin
      base_d  = line_addr_i[31:OW+2];
      start_d = line_addr_i[OW+1:2];
      ic_d    = '0;
      rc_d    = '0;
    end
    if (gnt_fire) begin
      ic_d = ic_q + CW'(1);
    end
    if (rsp_fire) begin
      line_d[wr_idx] = mem_rdata_i;
      rc_d           = rc_q + CW'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (line_req_i) state_d = S_FETCH;
      S_FETCH: if (ic_d == LW_C) state_d = S_DRAIN;
      S_DRAIN: if (rc_d == LW_C) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    line_rsp_o = (state_q == S_RESP);
    busy_o     = (state_q != S_IDLE);
    mem_req_o  = issue_ok;
    mem_addr_o = '0;
    if (state_q == S_FETCH) begin
      mem_addr_o = {base_q, issue_idx, 2'b00};
    end
  end

  assign line_data_o = line_q;

endmodule

// File: tb/tb_srv_icache_refill.sv
module tb_srv_icache_refill;

  localparam int LWD = 4;
  localparam int LW  = 32 * LWD;
  localparam int MAXO = 2;

  logic          clk;
  logic          rst_n;
  logic          line_req_i;
  logic [31:0]   line_addr_i;
  logic          line_rsp_o;
  logic [LW-1:0] line_data_o;
  logic          busy_o;
  logic          mem_req_o;
  logic [31:0]   mem_addr_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [31:0]   mem_rdata_i;

  srv_icache_refill #(.LINE_WORDS(LWD), .MAX_OUTST(MAXO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .line_req_i  (line_req_i),
    .line_addr_i (line_addr_i),
    .line_rsp_o  (line_rsp_o),
    .line_data_o (line_data_o),
    .busy_o      (busy_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model configuration (written by the main sequence only)
  int stall_beat = -1;
  int stall_len  = 0;
  int rv_delay   = 1;

  // Memory model observations (written by the model only)
  typedef struct {
    int          due;
    logic [31:0] data;
  } beat_t;
  beat_t        pq[$];
  logic [31:0]  alog[$];
  int g_tot = 0, r_tot = 0, both_cnt = 0, stall_cnt = 0, viol = 0, stable_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + {30'b0, a[3:2]} + (a[13] ? 32'h10 : 32'h0);
  endfunction

  // Memory: grants requests (optionally stalling one beat) and returns data
  // rv_delay cycles after each grant, in order.
  initial begin : mem_model
    int    cyc;
    int    bcnt;
    int    sctr;
    logic  prev_pend;
    logic [31:0] prev_addr;
    logic  gnt, rv;
    logic [31:0] rd;
    cyc = 0; bcnt = 0; sctr = 0; prev_pend = 1'b0; prev_addr = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (prev_pend && rst_n && (!mem_req_o || mem_addr_o != prev_addr)) stable_err++;
      if (!busy_o) begin bcnt = 0; sctr = 0; end
      if (mem_req_o && (g_tot - r_tot) >= MAXO) viol++;
      rv = 1'b0; rd = '0;
      if (pq.size() > 0 && pq[0].due <= cyc) begin
        rv = 1'b1; rd = pq[0].data;
        void'(pq.pop_front());
        r_tot++;
      end
      gnt = 1'b0;
      if (mem_req_o) begin
        if (bcnt == stall_beat && sctr < stall_len) begin
          sctr++; stall_cnt++;
        end else begin
          gnt = 1'b1;
          pq.push_back('{due: cyc + rv_delay, data: mem_word(mem_addr_o)});
          alog.push_back(mem_addr_o);
          g_tot++; bcnt++;
        end
      end
      if (gnt && rv) both_cnt++;
      prev_pend = mem_req_o && !gnt;
      prev_addr = mem_addr_o;
      mem_gnt_i = gnt; mem_rvalid_i = rv; mem_rdata_i = rd;
      cyc++;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Issues one refill; lat counts clock edges from the capture edge to the
  // response cycle (capture edge counts as 1).
  task automatic refill(input logic [31:0] addr, input bit hold,
                        output int lat, output int np, output logic [LW-1:0] data);
    @(negedge clk);
    line_req_i = 1'b1; line_addr_i = addr;
    @(posedge clk);
    lat = 1; np = 0; data = '0;
    @(negedge clk);
    if (!hold) line_req_i = 1'b0;
    while (!line_rsp_o && lat < 200) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    if (line_rsp_o) begin np = 1; data = line_data_o; end
    line_req_i = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      if (line_rsp_o) np++;
    end
  endtask

  localparam logic [LW-1:0] LINE_A = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [LW-1:0] LINE_B = {32'hB3, 32'hB2, 32'hB1, 32'hB0};

  initial begin : main
    int lat, np, a0, s0, e0, v0, b0, g0, r0, n;
    logic [LW-1:0] d;
    rst_n = 1'b0; line_req_i = 1'b0; line_addr_i = '0;
    #12;
    chk("rst_rsp",   line_rsp_o,  0);
    chk("rst_busy",  busy_o,      0);
    chk("rst_req",   mem_req_o,   0);
    chk("rst_addr",  mem_addr_o,  0);
    chk("rst_data",  line_data_o, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait refill, wrap-around order
    a0 = alog.size();
    refill(32'h0000_1008, 1'b0, lat, np, d);
    chk("zw_lat",   lat, 6);
    chk("zw_pulse", np, 1);
    chk("zw_line",  d, LINE_A);
    chk("zw_a0", alog[a0+0], 32'h1008);
    chk("zw_a1", alog[a0+1], 32'h100C);
    chk("zw_a2", alog[a0+2], 32'h1000);
    chk("zw_a3", alog[a0+3], 32'h1004);
    chk("zw_idle", busy_o, 0);

    // Grant stall on beat 1
    stall_beat = 1; stall_len = 3; s0 = stall_cnt; e0 = stable_err;
    refill(32'h0000_1004, 1'b0, lat, np, d);
    chk("st_lat",    lat, 9);
    chk("st_pulse",  np, 1);
    chk("st_line",   d, LINE_A);
    chk("st_cycles", stall_cnt - s0, 3);
    chk("st_stable", stable_err - e0, 0);
    stall_beat = -1; stall_len = 0;

    // Slow returns: outstanding limit must throttle requests
    rv_delay = 4; v0 = viol;
    refill(32'h0000_100C, 1'b0, lat, np, d);
    chk("mo_lat",   lat, 12);
    chk("mo_pulse", np, 1);
    chk("mo_line",  d, LINE_A);
    chk("mo_viol",  viol - v0, 0);
    rv_delay = 1;

    // Grant and return in the same cycle
    b0 = both_cnt; g0 = g_tot; r0 = r_tot;
    refill(32'h0000_300C, 1'b0, lat, np, d);
    chk("sc_lat",   lat, 6);
    chk("sc_line",  d, LINE_B);
    chk("sc_both",  both_cnt - b0, 3);
    chk("sc_gnts",  g_tot - g0, 4);
    chk("sc_rvs",   r_tot - r0, 4);

    // Request held through RESP, dropped in the response cycle
    refill(32'h0000_1000, 1'b1, lat, np, d);
    chk("hd_lat",   lat, 6);
    chk("hd_pulse", np, 1);
    chk("hd_idle",  busy_o, 0);

    // Request still high after RESP starts a second refill
    @(negedge clk);
    line_req_i = 1'b1; line_addr_i = 32'h0000_2004; n = 0;
    do begin @(posedge clk); @(negedge clk); n++; end while (!line_rsp_o && n < 100);
    chk("h2_rsp", line_rsp_o, 1);
    @(posedge clk); @(negedge clk);
    chk("h2_gap_busy", busy_o, 0);
    chk("h2_gap_rsp",  line_rsp_o, 0);
    @(posedge clk); @(negedge clk);
    chk("h2_restart", busy_o, 1);
    line_req_i = 1'b0; n = 0;
    while (!line_rsp_o && n < 100) begin @(posedge clk); @(negedge clk); n++; end
    chk("h2_line", line_data_o, LINE_B);
    repeat (3) @(negedge clk);

    // Reset mid-FETCH with two beats granted
    rv_delay = 4; g0 = g_tot;
    @(negedge clk);
    line_req_i = 1'b1; line_addr_i = 32'h0000_1008;
    @(posedge clk); @(negedge clk);
    line_req_i = 1'b0;
    for (int k = 0; k < 20 && (g_tot - g0) < 2; k++) begin @(negedge clk); #1; end
    chk("rs_granted", g_tot - g0, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("rs_busy", busy_o, 0);
    chk("rs_req",  mem_req_o, 0);
    chk("rs_addr", mem_addr_o, 0);
    chk("rs_rsp",  line_rsp_o, 0);
    chk("rs_data", line_data_o, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k < 30 && pq.size() > 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("rs_drained",  pq.size(), 0);
    chk("rs_stale_busy", busy_o, 0);
    chk("rs_stale_data", line_data_o, 0);
    rv_delay = 1;
    refill(32'h0000_2000, 1'b0, lat, np, d);
    chk("rs_new_lat",  lat, 6);
    chk("rs_new_line", d, LINE_B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
